// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: fetch port, data port,
// shared external memory port and the sticky error flag.
interface mem_arbiter_if;
    // fetch (instruction) port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    // memory-stage (data) port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;

    // shared external memory
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;

    // sticky timeout indication
    logic        err;

    // arbiter side
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
               ext_ack, ext_rdata,
        output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
               ext_req, ext_we, ext_addr, ext_wdata, err
    );

    // requesters + external memory side
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
               ext_ack, ext_rdata,
        input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
               ext_req, ext_we, ext_addr, ext_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one external memory between the fetch stage
// and the memory stage. The data port wins ties; every access is bounded by a
// wait counter and aborted with ERR_WORD and a sticky err flag on timeout.
module mem_arbiter #(
    parameter int          MAX_WAIT = 15,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    // Counter must hold the value MAX_WAIT itself.
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        IF_BUSY  = 2'b01,
        MEM_BUSY = 2'b10
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              ext_req_r;
    logic              ext_we_r;
    logic [31:0]       ext_addr_r;
    logic [31:0]       ext_wdata_r;
    logic [31:0]       if_rdata_r;
    logic              if_done_r;
    logic [31:0]       mem_rdata_r;
    logic              mem_done_r;
    logic              err_r;

    // A requester is eligible in IDLE only if it is not being acknowledged in
    // this very cycle; its req is still high during the done pulse.
    logic mem_eligible_s;
    logic if_eligible_s;
    logic timeout_s;

    assign mem_eligible_s = bus.mem_req & ~mem_done_r;
    assign if_eligible_s  = bus.if_req  & ~if_done_r;
    // Abort happens on the BUSY cycle whose count already equals MAX_WAIT and
    // still has no ack; an ack in that same cycle wins.
    assign timeout_s      = (wait_cnt_r == MAX_CNT);

    // Arbitration FSM with all bus-facing outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            ext_req_r   <= 1'b0;
            ext_we_r    <= 1'b0;
            ext_addr_r  <= 32'h0000_0000;
            ext_wdata_r <= 32'h0000_0000;
            if_rdata_r  <= 32'h0000_0000;
            if_done_r   <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
            mem_done_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            // done strobes are single-cycle unless re-armed below
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;

            case (state_r)
                IDLE: begin
                    wait_cnt_r <= '0;
                    if (mem_eligible_s) begin
                        ext_req_r   <= 1'b1;
                        ext_we_r    <= bus.mem_we;
                        ext_addr_r  <= bus.mem_addr;
                        ext_wdata_r <= bus.mem_wdata;
                        state_r     <= MEM_BUSY;
                    end else if (if_eligible_s) begin
                        ext_req_r   <= 1'b1;
                        ext_we_r    <= 1'b0;
                        ext_addr_r  <= bus.if_addr;
                        state_r     <= IF_BUSY;
                    end else begin
                        ext_req_r   <= 1'b0;
                        state_r     <= IDLE;
                    end
                end

                IF_BUSY: begin
                    if (bus.ext_ack) begin
                        if_rdata_r <= bus.ext_rdata;
                        if_done_r  <= 1'b1;
                        ext_req_r  <= 1'b0;
                        state_r    <= IDLE;
                    end else if (timeout_s) begin
                        if_rdata_r <= ERR_WORD;
                        if_done_r  <= 1'b1;
                        ext_req_r  <= 1'b0;
                        err_r      <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                        state_r    <= IF_BUSY;
                    end
                end

                MEM_BUSY: begin
                    if (bus.ext_ack) begin
                        if (!ext_we_r) begin
                            mem_rdata_r <= bus.ext_rdata;
                        end else begin
                            mem_rdata_r <= mem_rdata_r;
                        end
                        mem_done_r <= 1'b1;
                        ext_req_r  <= 1'b0;
                        state_r    <= IDLE;
                    end else if (timeout_s) begin
                        if (!ext_we_r) begin
                            mem_rdata_r <= ERR_WORD;
                        end else begin
                            mem_rdata_r <= mem_rdata_r;
                        end
                        mem_done_r <= 1'b1;
                        ext_req_r  <= 1'b0;
                        err_r      <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                        state_r    <= MEM_BUSY;
                    end
                end

                default: begin
                    // unreachable encoding: drop any request and recover
                    wait_cnt_r <= '0;
                    ext_req_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Stalls depend only on the live request and the registered done strobe.
    assign bus.if_stall  = bus.if_req  & ~if_done_r;
    assign bus.mem_stall = bus.mem_req & ~mem_done_r;

    assign bus.ext_req   = ext_req_r;
    assign bus.ext_we    = ext_we_r;
    assign bus.ext_addr  = ext_addr_r;
    assign bus.ext_wdata = ext_wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign bus.mem_done  = mem_done_r;
    assign bus.err       = err_r;

endmodule
